// File: rtl/conv_channel_sched_if.sv
// Signals between the per-channel filters, the shared converter and the DAC side of conv_channel_sched.
interface conv_channel_sched_if #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 16
);
  logic             l_we;
  logic [IN_W-1:0]  l_data;
  logic             r_we;
  logic [IN_W-1:0]  r_data;
  logic             conv_we;
  logic [IN_W-1:0]  conv_data;
  logic             conv_re;
  logic [OUT_W-1:0] conv_q;
  logic [OUT_W-1:0] l_out;
  logic             l_valid;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;
  logic             clr_err;
  logic             ovf_l;
  logic             ovf_r;
  logic             to_err;

  modport slave (
    input  l_we, l_data, r_we, r_data, conv_re, conv_q, clr_err,
    output conv_we, conv_data, l_out, l_valid, r_out, r_valid, ovf_l, ovf_r, to_err
  );

  modport master (
    output l_we, l_data, r_we, r_data, conv_re, conv_q, clr_err,
    input  conv_we, conv_data, l_out, l_valid, r_out, r_valid, ovf_l, ovf_r, to_err
  );
endinterface

// File: rtl/conv_channel_sched.sv
// Round-robin sharing of one converter between left and right channels, with one pending
// sample per channel, a single outstanding transaction and a result timeout.
module conv_channel_sched #(
  parameter int IN_W    = 34,
  parameter int OUT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  conv_channel_sched_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] l_hold, r_hold;
  logic            pend_l, pend_r;
  logic            last_l;
  logic            cur_l;
  logic [CW-1:0]   cnt;
  logic            issue, grant_l, done, timeout;
  logic            issue_l, issue_r;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Left wins a tie unless it was the last channel granted.
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    grant_l   = 1'b0;
    done      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (pend_l || pend_r) begin
          issue     = 1'b1;
          grant_l   = pend_l && (!pend_r || !last_l);
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (bus.conv_re) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign issue_l = issue && grant_l;
  assign issue_r = issue && !grant_l;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_hold        <= '0;
      r_hold        <= '0;
      pend_l        <= 1'b0;
      pend_r        <= 1'b0;
      last_l        <= 1'b0;
      cur_l         <= 1'b0;
      cnt           <= '0;
      bus.conv_we   <= 1'b0;
      bus.conv_data <= '0;
      bus.l_out     <= '0;
      bus.l_valid   <= 1'b0;
      bus.r_out     <= '0;
      bus.r_valid   <= 1'b0;
      bus.ovf_l     <= 1'b0;
      bus.ovf_r     <= 1'b0;
      bus.to_err    <= 1'b0;
    end else begin
      bus.conv_we <= issue;
      bus.l_valid <= done && cur_l;
      bus.r_valid <= done && !cur_l;

      if (issue) begin
        bus.conv_data <= grant_l ? l_hold : r_hold;
        cur_l         <= grant_l;
        last_l        <= grant_l;
        cnt           <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + CW'(1);
      end

      if (done) begin
        if (cur_l) bus.l_out <= bus.conv_q;
        else       bus.r_out <= bus.conv_q;
      end

      // A capture in the issuing cycle refills the slot, so pend stays set.
      if (bus.l_we) begin
        l_hold <= bus.l_data;
        pend_l <= 1'b1;
      end else if (issue_l) begin
        pend_l <= 1'b0;
      end

      if (bus.r_we) begin
        r_hold <= bus.r_data;
        pend_r <= 1'b1;
      end else if (issue_r) begin
        pend_r <= 1'b0;
      end

      if (bus.l_we && pend_l && !issue_l) bus.ovf_l <= 1'b1;
      else if (bus.clr_err)               bus.ovf_l <= 1'b0;

      if (bus.r_we && pend_r && !issue_r) bus.ovf_r <= 1'b1;
      else if (bus.clr_err)               bus.ovf_r <= 1'b0;

      if (timeout)          bus.to_err <= 1'b1;
      else if (bus.clr_err) bus.to_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_conv_channel_sched.sv
// Directed scenarios with literal expectations plus a randomized run, all cross-checked
// every cycle against a channel-level behavioural model.
module tb_conv_channel_sched;
  localparam int IN_W    = 34;
  localparam int OUT_W   = 16;
  localparam int TIMEOUT = 8;

  logic clk;
  logic rst_n;
  bit   check_en;
  int   checks;
  int   errors;

  conv_channel_sched_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  conv_channel_sched #(.IN_W(IN_W), .OUT_W(OUT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: index 0 is left, 1 is right.
  logic [IN_W-1:0]  m_hold [2];
  bit               m_pend [2];
  logic [OUT_W-1:0] m_out [2];
  bit               m_valid [2];
  bit               m_ovf [2];
  bit               m_to_err;
  bit               m_conv_we;
  logic [IN_W-1:0]  m_conv_data;
  bit               m_busy;
  int               m_inflight;
  int               m_age;
  int               m_last;
  int               m_issued;
  bit               m_ovf_evt;
  bit               m_we [2];
  logic [IN_W-1:0]  m_din [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    m_we[0]  = bus.l_we;
    m_we[1]  = bus.r_we;
    m_din[0] = bus.l_data;
    m_din[1] = bus.r_data;
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        m_pend[c]  = 1'b0;
        m_out[c]   = '0;
        m_valid[c] = 1'b0;
        m_ovf[c]   = 1'b0;
        m_hold[c]  = '0;
      end
      m_to_err    = 1'b0;
      m_conv_we   = 1'b0;
      m_conv_data = '0;
      m_busy      = 1'b0;
      m_last      = 1;
      m_age       = 0;
      m_inflight  = 0;
    end else begin
      m_issued   = -1;
      m_conv_we  = 1'b0;
      m_valid[0] = 1'b0;
      m_valid[1] = 1'b0;
      if (!m_busy) begin
        if (m_pend[0] || m_pend[1]) begin
          if (m_pend[0] && m_pend[1]) m_issued = 1 - m_last;
          else                        m_issued = m_pend[0] ? 0 : 1;
          m_conv_we   = 1'b1;
          m_conv_data = m_hold[m_issued];
          m_inflight  = m_issued;
          m_last      = m_issued;
          m_age       = 0;
          m_busy      = 1'b1;
        end
      end else begin
        m_age++;
        if (bus.conv_re) begin
          m_out[m_inflight]   = bus.conv_q;
          m_valid[m_inflight] = 1'b1;
          m_busy              = 1'b0;
        end else if (m_age == TIMEOUT) begin
          m_to_err = 1'b1;
          m_busy   = 1'b0;
        end else if (bus.clr_err) begin
          m_to_err = 1'b0;
        end
      end
      if (m_issued != -1 || !m_busy && !m_to_err) begin
        if (bus.clr_err && !(m_busy == 1'b0 && m_age == TIMEOUT && m_to_err)) m_to_err = m_to_err;
      end
      for (int c = 0; c < 2; c++) begin
        m_ovf_evt = m_we[c] && m_pend[c] && (m_issued != c);
        if (m_we[c]) begin
          m_hold[c] = m_din[c];
          m_pend[c] = 1'b1;
        end else if (m_issued == c) begin
          m_pend[c] = 1'b0;
        end
        if (m_ovf_evt)        m_ovf[c] = 1'b1;
        else if (bus.clr_err) m_ovf[c] = 1'b0;
      end
    end
  endtask

  // Timeout flag clearing is applied in a separate step so that a timeout in the same cycle wins.
  bit m_to_evt;
  task automatic modelClear();
    if (rst_n && bus.clr_err && !m_to_evt) m_to_err = 1'b0;
  endtask

  always @(posedge clk) begin
    m_to_evt = m_busy && !bus.conv_re && (m_age + 1 == TIMEOUT) && rst_n;
    modelStep();
    modelClear();
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("conv_we",   64'(bus.conv_we),   64'(m_conv_we));
      checkOutput("conv_data", 64'(bus.conv_data), 64'(m_conv_data));
      checkOutput("l_out",     64'(bus.l_out),     64'(m_out[0]));
      checkOutput("l_valid",   64'(bus.l_valid),   64'(m_valid[0]));
      checkOutput("r_out",     64'(bus.r_out),     64'(m_out[1]));
      checkOutput("r_valid",   64'(bus.r_valid),   64'(m_valid[1]));
      checkOutput("ovf_l",     64'(bus.ovf_l),     64'(m_ovf[0]));
      checkOutput("ovf_r",     64'(bus.ovf_r),     64'(m_ovf[1]));
      checkOutput("to_err",    64'(bus.to_err),    64'(m_to_err));
    end
  end

  // Drives one cycle of inputs, then returns at the next falling edge.
  task automatic applyStimulus(input bit lwe, input logic [IN_W-1:0] ld,
                               input bit rwe, input logic [IN_W-1:0] rd,
                               input bit re, input logic [OUT_W-1:0] q, input bit clr);
    bus.l_we    = lwe;
    bus.l_data  = ld;
    bus.r_we    = rwe;
    bus.r_data  = rd;
    bus.conv_re = re;
    bus.conv_q  = q;
    bus.clr_err = clr;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
  endtask

  task automatic lWe(input logic [IN_W-1:0] d);
    applyStimulus(1'b1, d, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic rWe(input logic [IN_W-1:0] d);
    applyStimulus(1'b0, '0, 1'b1, d, 1'b0, '0, 1'b0);
  endtask

  task automatic convRe(input logic [OUT_W-1:0] q);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b1, q, 1'b0);
  endtask

  initial begin
    logic [IN_W-1:0] dl, dr;
    bit lwe, rwe, re, clr;
    checks   = 0;
    errors   = 0;
    check_en = 1'b0;
    rst_n    = 1'b0;
    bus.l_we = 1'b0; bus.l_data = '0; bus.r_we = 1'b0; bus.r_data = '0;
    bus.conv_re = 1'b0; bus.conv_q = '0; bus.clr_err = 1'b0;
    @(negedge clk);
    doReset();
    check_en = 1'b1;
    checkOutput("reset conv_we", 64'(bus.conv_we), 64'd0);
    checkOutput("reset l_out", 64'(bus.l_out), 64'd0);
    checkOutput("reset to_err", 64'(bus.to_err), 64'd0);

    // Basic latency on the left channel.
    lWe(34'h0_0001_2345);
    checkOutput("t1 conv_we c1", 64'(bus.conv_we), 64'd0);
    idle(1);
    checkOutput("t1 conv_we c2", 64'(bus.conv_we), 64'd1);
    checkOutput("t1 conv_data", 64'(bus.conv_data), 64'h0_0001_2345);
    idle(1);
    checkOutput("t1 l_valid c3", 64'(bus.l_valid), 64'd0);
    convRe(16'hA5A5);
    checkOutput("t1 l_valid c4", 64'(bus.l_valid), 64'd1);
    checkOutput("t1 l_out", 64'(bus.l_out), 64'hA5A5);
    idle(1);
    checkOutput("t1 l_valid c5", 64'(bus.l_valid), 64'd0);

    // Simultaneous capture: left first, right at cycle 5.
    doReset();
    applyStimulus(1'b1, 34'h2_0000_0001, 1'b1, 34'h0_0000_0ABC, 1'b0, '0, 1'b0);
    idle(1);
    checkOutput("t2 conv_data L", 64'(bus.conv_data), 64'h2_0000_0001);
    idle(1);
    convRe(16'h1111);
    checkOutput("t2 l_valid", 64'(bus.l_valid), 64'd1);
    checkOutput("t2 l_out", 64'(bus.l_out), 64'h1111);
    idle(1);
    checkOutput("t2 conv_we c5", 64'(bus.conv_we), 64'd1);
    checkOutput("t2 conv_data R", 64'(bus.conv_data), 64'h0_0000_0ABC);
    idle(1);
    convRe(16'h2222);
    checkOutput("t2 r_valid", 64'(bus.r_valid), 64'd1);
    checkOutput("t2 r_out", 64'(bus.r_out), 64'h2222);
    checkOutput("t2 ovf_l", 64'(bus.ovf_l), 64'd0);
    checkOutput("t2 ovf_r", 64'(bus.ovf_r), 64'd0);

    // Overwrites while the converter stalls.
    doReset();
    lWe(34'h0_0000_00D0);
    idle(1);
    lWe(34'h0_0000_000A);
    idle(1);
    lWe(34'h0_0000_000B);
    checkOutput("t3 ovf_l", 64'(bus.ovf_l), 64'd1);
    idle(1);
    lWe(34'h3_FFFF_FFCC);
    convRe(16'h3333);
    checkOutput("t3 l_out D0", 64'(bus.l_out), 64'h3333);
    idle(1);
    checkOutput("t3 conv_data last", 64'(bus.conv_data), 64'h3_FFFF_FFCC);
    convRe(16'h4444);
    checkOutput("t3 l_out last", 64'(bus.l_out), 64'h4444);
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
    checkOutput("t3 ovf_l cleared", 64'(bus.ovf_l), 64'd0);

    // Timeout, stray result ignored, queued right sample still issues.
    doReset();
    lWe(34'h0_0000_0055);
    idle(1);
    rWe(34'h1_2345_6789);
    idle(6);
    checkOutput("t4 to_err c9", 64'(bus.to_err), 64'd0);
    idle(1);
    checkOutput("t4 to_err c10", 64'(bus.to_err), 64'd1);
    checkOutput("t4 l_valid", 64'(bus.l_valid), 64'd0);
    convRe(16'h5555);
    checkOutput("t4 stray l_valid", 64'(bus.l_valid), 64'd0);
    checkOutput("t4 conv_data R", 64'(bus.conv_data), 64'h1_2345_6789);
    idle(1);
    convRe(16'h6666);
    checkOutput("t4 r_out", 64'(bus.r_out), 64'h6666);

    // Reset during WAIT discards the transaction.
    doReset();
    lWe(34'h0_0000_0077);
    idle(1);
    doReset();
    checkOutput("t5 conv_we", 64'(bus.conv_we), 64'd0);
    convRe(16'h7777);
    checkOutput("t5 l_valid", 64'(bus.l_valid), 64'd0);
    checkOutput("t5 l_out", 64'(bus.l_out), 64'd0);
    lWe(34'h0_0000_0088);
    idle(1);
    checkOutput("t5 conv_data", 64'(bus.conv_data), 64'h0_0000_0088);
    idle(1);
    convRe(16'h8888);
    checkOutput("t5 l_out", 64'(bus.l_out), 64'h8888);

    // Alternating channels every 6 cycles.
    doReset();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) lWe(34'(i + 16));
      else            rWe(34'(i + 16));
      idle(2);
      convRe(16'(i * 16'h0101));
      if (i % 2 == 0) checkOutput("t6 l_out", 64'(bus.l_out), 64'(i * 16'h0101));
      else            checkOutput("t6 r_out", 64'(bus.r_out), 64'(i * 16'h0101));
      idle(2);
    end
    checkOutput("t6 to_err", 64'(bus.to_err), 64'd0);

    // Randomized traffic checked by the model only.
    for (int n = 0; n < 4000; n++) begin
      lwe   = ($urandom_range(0, 5) == 0);
      rwe   = ($urandom_range(0, 5) == 0);
      re    = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 15) == 0);
      dl    = {2'($urandom_range(0, 3)), 32'($urandom)};
      dr    = {2'($urandom_range(0, 3)), 32'($urandom)};
      rst_n = ($urandom_range(0, 199) != 0);
      applyStimulus(lwe, dl, rwe, dr, re, 16'($urandom), clr);
    end
    rst_n = 1'b1;
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
